// File: rtl/cnna_axi_pkg.sv
// Shared AXI constants, FSM state encoding and a log2 helper for the
// AXI-to-RAM read engines.
package cnna_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Error code reported when rlast disagrees with the counted beat.
  localparam logic [1:0] ERR_CODE_RLAST  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi2ram_burst_gen.sv
// Burst address generator: tracks the current DDR address and beats still to
// request, and presents araddr/arlen for the next INCR burst.
module axi2ram_burst_gen
  import cnna_axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 11,
  parameter int MAX_BURST = 16,
  parameter int BYTES     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              burst_done,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              last_burst
);

  localparam int          BEAT_W = 9;
  localparam int          BSHIFT = clog2(BYTES);
  localparam logic [31:0] MAX_U  = MAX_BURST;

  logic [ADDR_W-1:0] cur_reg;
  logic [LEN_W-1:0]  rem_reg;
  logic [BEAT_W-1:0] beats;

  always_comb begin
    beats = BEAT_W'(rem_reg);
    if (32'(rem_reg) >= MAX_U) beats = BEAT_W'(MAX_BURST);
  end

  assign araddr     = cur_reg;
  assign arlen      = 8'(beats - 9'd1);
  assign last_burst = (32'(rem_reg) <= MAX_U);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_reg <= '0;
      rem_reg <= '0;
    end else if (load) begin
      cur_reg <= base_addr;
      rem_reg <= len;
    end else if (burst_done) begin
      cur_reg <= cur_reg + (ADDR_W'(beats) << BSHIFT);
      rem_reg <= rem_reg - LEN_W'(beats);
    end
  end

endmodule

// File: rtl/axibus2rambus_mb.sv
// Multi-burst AXI4 read engine copying I_len beats from DDR into a buffer RAM.
// Optional response checking (O_err/O_err_code) is enabled by AXI2RAM_RESP_CHK_EN.
module axibus2rambus_mb
  import cnna_axi_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_MAX_BURST        = 16
) (
  input  logic                          I_clk,
  input  logic                          I_rst_n,
  input  logic                          I_ap_start,
  output logic                          O_ap_done,
  output logic                          O_ap_idle,
  output logic                          O_ap_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
  input  logic [C_RAM_ADDR_WIDTH-1:0]   I_ram_base,
  input  logic [C_RAM_ADDR_WIDTH:0]     I_len,
  output logic [C_RAM_ADDR_WIDTH-1:0]   O_waddr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] O_wdata,
  output logic                          O_wr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_araddr,
  output logic [7:0]                    O_maxi_arlen,
  output logic [2:0]                    O_maxi_arsize,
  output logic [1:0]                    O_maxi_arburst,
  output logic [C_M_AXI_ID_WIDTH-1:0]   O_maxi_arid,
  output logic                          O_maxi_arvalid,
  input  logic                          I_maxi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] I_maxi_rdata,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   I_maxi_rid,
  input  logic [1:0]                    I_maxi_rresp,
  input  logic                          I_maxi_rlast,
  input  logic                          I_maxi_rvalid,
  output logic                          O_maxi_rready
`ifdef AXI2RAM_RESP_CHK_EN
  ,
  output logic                          O_err,
  output logic [1:0]                    O_err_code
`endif
);

  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int LEN_W = C_RAM_ADDR_WIDTH + 1;

  state_t state_reg, state_next;

  logic [C_M_AXI_ADDR_WIDTH-1:0] cur_araddr;
  logic [7:0]                    cur_arlen;
  logic                          last_burst;
  logic [7:0]                    beat_cnt_reg;
  logic [C_RAM_ADDR_WIDTH-1:0]   ram_ptr_reg;
  logic                          wr_reg;
  logic [C_RAM_ADDR_WIDTH-1:0]   waddr_reg;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_reg;
  logic                          start_job;
  logic                          beat_hs;
  logic                          beat_last;

  assign start_job = (state_reg == ST_IDLE) && I_ap_start;
  assign beat_hs   = (state_reg == ST_R) && I_maxi_rvalid;
  // Burst end comes from our own beat count; rlast is only cross-checked.
  assign beat_last = beat_hs && (beat_cnt_reg == cur_arlen);

  axi2ram_burst_gen #(
    .ADDR_W    (C_M_AXI_ADDR_WIDTH),
    .LEN_W     (LEN_W),
    .MAX_BURST (C_MAX_BURST),
    .BYTES     (BYTES)
  ) u_burst_gen (
    .clk        (I_clk),
    .rst_n      (I_rst_n),
    .load       (start_job),
    .base_addr  (I_base_addr),
    .len        (I_len),
    .burst_done (beat_last),
    .araddr     (cur_araddr),
    .arlen      (cur_arlen),
    .last_burst (last_burst)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    O_maxi_arvalid = 1'b0;
    O_maxi_rready  = 1'b0;
    O_ap_done      = 1'b0;
    O_ap_ready     = 1'b0;
    O_ap_idle      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        O_ap_idle = 1'b1;
        if (I_ap_start) state_next = (I_len == '0) ? ST_DONE : ST_AR;
      end
      ST_AR: begin
        O_maxi_arvalid = 1'b1;
        if (I_maxi_arready) state_next = ST_R;
      end
      ST_R: begin
        O_maxi_rready = 1'b1;
        if (beat_last) state_next = last_burst ? ST_DONE : ST_AR;
      end
      ST_DONE: begin
        O_ap_done  = 1'b1;
        O_ap_ready = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign O_maxi_araddr  = O_maxi_arvalid ? cur_araddr : '0;
  assign O_maxi_arlen   = O_maxi_arvalid ? cur_arlen : 8'd0;
  assign O_maxi_arsize  = 3'(clog2(BYTES));
  assign O_maxi_arburst = AXI_BURST_INCR;
  assign O_maxi_arid    = '0;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      beat_cnt_reg <= 8'd0;
      ram_ptr_reg  <= '0;
    end else begin
      if (state_reg == ST_AR && I_maxi_arready) beat_cnt_reg <= 8'd0;
      else if (beat_hs)                         beat_cnt_reg <= beat_cnt_reg + 8'd1;
      // ram_ptr wraps naturally at the RAM size.
      if (start_job)    ram_ptr_reg <= I_ram_base;
      else if (beat_hs) ram_ptr_reg <= ram_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      wr_reg <= beat_hs;
      if (beat_hs) begin
        waddr_reg <= ram_ptr_reg;
        wdata_reg <= I_maxi_rdata;
      end
    end
  end

  assign O_wr    = wr_reg;
  assign O_waddr = waddr_reg;
  assign O_wdata = wdata_reg;

`ifdef AXI2RAM_RESP_CHK_EN
  logic       err_reg;
  logic [1:0] err_code_reg;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
    end else if (start_job) begin
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
    end else if (beat_hs) begin
      if (I_maxi_rlast != beat_last) begin
        err_reg      <= 1'b1;
        err_code_reg <= ERR_CODE_RLAST;
      end else if (I_maxi_rresp != AXI_RESP_OKAY) begin
        err_reg      <= 1'b1;
        err_code_reg <= I_maxi_rresp;
      end
    end
  end

  assign O_err      = err_reg;
  assign O_err_code = err_code_reg;

  logic unused_sink;
  assign unused_sink = ^I_maxi_rid;
`else
  logic unused_sink;
  assign unused_sink = ^{I_maxi_rid, I_maxi_rresp, I_maxi_rlast};
`endif

endmodule
